// File: rtl/fifo_stream_reader.sv
// Pops words from a sync_fifo read port and presents them as a valid/ready stream
// framed into BURST_LEN-beat bursts; a 2-entry skid buffer hides the FIFO read latency.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int unsigned BEAT_W = 16;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pop_out;
  logic [1:0]            pending;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = head_q;
  assign m_last   = m_valid && (beat_q == BEAT_MAX);
  assign word_cnt = cnt_q;
  assign pop_out  = m_valid && m_ready;

  // Words still owed to the sink after this cycle; pop_out implies occ_q >= 1.
  assign pending    = occ_q + 2'(inflight_q) - 2'(pop_out);
  assign fifo_rd_en = rst_n && en && !fifo_empty && (pending < 2'd2);

  // Skid buffer: head_q is the oldest word, tail_q the second.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    cnt_d  = cnt_q;
    case ({inflight_q, pop_out})
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = fifo_data_out;
        end else begin
          head_d = tail_q;
          tail_d = fifo_data_out;
        end
      end
      2'b10: begin
        if (occ_q == 2'd0) head_d = fifo_data_out;
        else               tail_d = fifo_data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      default: ;
    endcase
    if (pop_out) begin
      beat_d = m_last ? '0 : beat_q + BEAT_W'(1);
      cnt_d  = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
